// File: rtl/mkgauss_seq.sv
// Handshaked Falcon discrete Gaussian sampler: sums g CDT samples, each drawn from two
// 64-bit PRNG words, with the table scan spread over several cycles.
module mkgauss_seq #(
  parameter int unsigned CMP_PER_CYC = 2,
  parameter int unsigned VAL_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cfg_logn,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [63:0]      r_word,
  output logic             val_valid,
  input  logic             val_ready,
  output logic [VAL_W-1:0] val,
  output logic             busy
);

  localparam int unsigned TBL_LAST = 26;
  localparam int unsigned K_W      = 6;
  localparam int unsigned G_W      = 11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    SCAN = 3'd3,
    ACC  = 3'd4,
    OUT  = 3'd5
  } state_t;

  // Falcon gauss_1024_12289 cumulative distribution table.
  function automatic logic [63:0] cdt(input logic [K_W-1:0] idx);
    logic [63:0] t;
    case (idx)
      6'd0:    t = 64'd1283868770400643928;
      6'd1:    t = 64'd6416574995475331444;
      6'd2:    t = 64'd4078260278032692663;
      6'd3:    t = 64'd2353523259288686585;
      6'd4:    t = 64'd1227179971273316331;
      6'd5:    t = 64'd575931623374121527;
      6'd6:    t = 64'd242543240509105209;
      6'd7:    t = 64'd91437049221049666;
      6'd8:    t = 64'd30799446349977173;
      6'd9:    t = 64'd9255276791179340;
      6'd10:   t = 64'd2478152334826140;
      6'd11:   t = 64'd590642893610164;
      6'd12:   t = 64'd125206034929641;
      6'd13:   t = 64'd23590435911403;
      6'd14:   t = 64'd3948334035941;
      6'd15:   t = 64'd586753615614;
      6'd16:   t = 64'd77391054539;
      6'd17:   t = 64'd9056793210;
      6'd18:   t = 64'd940121950;
      6'd19:   t = 64'd86539696;
      6'd20:   t = 64'd7062824;
      6'd21:   t = 64'd510971;
      6'd22:   t = 64'd32764;
      6'd23:   t = 64'd1862;
      6'd24:   t = 64'd93;
      6'd25:   t = 64'd4;
      default: t = 64'd0;
    endcase
    return t;
  endfunction

  state_t             state_q, state_d;
  logic [G_W-1:0]     g_q, g_d, g_new;
  logic [G_W-1:0]     iter_q, iter_d, iter_inc;
  logic [VAL_W-1:0]   acc_q, acc_d, v_ext;
  logic               neg_q, neg_d;
  logic               f_q, f_d;
  logic [63:0]        r2_q, r2_d;
  logic [K_W-1:0]     v_q, v_d;
  logic [K_W-1:0]     k_q, k_d, kk;
  logic               hit;
  logic [VAL_W-1:0]   val_q, val_d;
  logic               val_valid_q, val_valid_d;
  logic               r_ready_q, r_ready_d;
  logic               busy_q, busy_d;
  logic               xfer_in;
  logic               xfer_out;

  assign xfer_in  = r_valid && r_ready_q;
  assign xfer_out = val_valid_q && val_ready;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    iter_d      = iter_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    f_d         = f_q;
    r2_d        = r2_q;
    v_d         = v_q;
    k_d         = k_q;
    val_d       = val_q;
    val_valid_d = val_valid_q;
    kk          = '0;
    hit         = 1'b0;
    iter_inc    = iter_q + G_W'(1);
    v_ext       = VAL_W'(v_q);
    g_new       = G_W'(1);
    if (cfg_logn >= 4'd1 && cfg_logn <= 4'd10) begin
      g_new = G_W'(1) << (4'd10 - cfg_logn);
    end

    unique case (state_q)
      IDLE: begin
        if (xfer_in) begin
          g_d     = g_new;
          acc_d   = '0;
          iter_d  = '0;
          neg_d   = r_word[63];
          f_d     = ({1'b0, r_word[62:0]} < cdt(K_W'(0)));
          state_d = W1;
        end
      end
      W0: begin
        if (xfer_in) begin
          neg_d   = r_word[63];
          f_d     = ({1'b0, r_word[62:0]} < cdt(K_W'(0)));
          state_d = W1;
        end
      end
      W1: begin
        if (xfer_in) begin
          r2_d    = {1'b0, r_word[62:0]};
          v_d     = '0;
          k_d     = K_W'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        // First table hit wins; a hit on the first word suppresses all later ones.
        for (int unsigned j = 0; j < CMP_PER_CYC; j++) begin
          kk  = k_q + K_W'(j);
          hit = (r2_q >= cdt(kk));
          if (hit && !f_d) begin
            v_d = kk;
          end
          f_d = f_d | hit;
        end
        k_d = k_q + K_W'(CMP_PER_CYC);
        if (int'(k_q) + int'(CMP_PER_CYC) > int'(TBL_LAST)) begin
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d  = neg_q ? (acc_q - v_ext) : (acc_q + v_ext);
        iter_d = iter_inc;
        if (iter_inc == g_q) begin
          val_d       = acc_d;
          val_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          state_d = W0;
        end
      end
      OUT: begin
        if (xfer_out) begin
          val_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    r_ready_d = (state_d == IDLE) || (state_d == W0) || (state_d == W1);
    busy_d    = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= G_W'(1);
      iter_q      <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      f_q         <= 1'b0;
      r2_q        <= '0;
      v_q         <= '0;
      k_q         <= '0;
      val_q       <= '0;
      val_valid_q <= 1'b0;
      r_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      iter_q      <= iter_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      f_q         <= f_d;
      r2_q        <= r2_d;
      v_q         <= v_d;
      k_q         <= k_d;
      val_q       <= val_d;
      val_valid_q <= val_valid_d;
      r_ready_q   <= r_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign r_ready   = r_ready_q;
  assign val_valid = val_valid_q;
  assign val       = val_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mkgauss_seq.sv
// Self-checking bench for mkgauss_seq against a word-level model of the Falcon mkgauss loop.
module tb_mkgauss_seq;

  localparam logic [63:0] CDT [0:26] = '{
    64'd1283868770400643928, 64'd6416574995475331444, 64'd4078260278032692663,
    64'd2353523259288686585, 64'd1227179971273316331, 64'd575931623374121527,
    64'd242543240509105209,  64'd91437049221049666,   64'd30799446349977173,
    64'd9255276791179340,    64'd2478152334826140,    64'd590642893610164,
    64'd125206034929641,     64'd23590435911403,      64'd3948334035941,
    64'd586753615614,        64'd77391054539,         64'd9056793210,
    64'd940121950,           64'd86539696,            64'd7062824,
    64'd510971,              64'd32764,               64'd1862,
    64'd93,                  64'd4,                   64'd0
  };
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_logn = 4'd9;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [63:0] r_word = '0;
  logic        val_valid;
  logic        val_ready = 1'b1;
  logic [31:0] val;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] wbuf [0:1023];

  always #5 clk = ~clk;

  mkgauss_seq #(.CMP_PER_CYC(2), .VAL_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_logn(cfg_logn),
    .r_valid(r_valid), .r_ready(r_ready), .r_word(r_word),
    .val_valid(val_valid), .val_ready(val_ready), .val(val), .busy(busy)
  );

  function automatic int g_of(input logic [3:0] logn);
    return (logn >= 4'd1 && logn <= 4'd10) ? (1 << (10 - int'(logn))) : 1;
  endfunction

  // Falcon mkgauss: sum of g signed CDT draws, two words per draw.
  function automatic int model(input logic [3:0] logn);
    int acc, v;
    logic [63:0] r1, r2;
    bit neg, f;
    acc = 0;
    for (int i = 0; i < g_of(logn); i++) begin
      r1 = wbuf[2*i];
      r2 = wbuf[2*i+1];
      neg = r1[63];
      r1[63] = 1'b0;
      r2[63] = 1'b0;
      f = (r1 < CDT[0]);
      v = 0;
      if (!f) begin
        for (int k = 1; k <= 26; k++) begin
          if (r2 >= CDT[k]) begin
            v = k;
            break;
          end
        end
      end
      acc += neg ? -v : v;
    end
    return acc;
  endfunction

  task automatic send_word(input logic [63:0] w, input int max_gap, output bit ok);
    int n;
    ok = 1'b1;
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    @(negedge clk);
    r_valid = 1'b1;
    r_word  = w;
    n = 0;
    while (r_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (r_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_word: r_ready=%b, required 1 within 400 cycles", r_ready);
      r_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    r_valid = 1'b0;
  endtask

  task automatic wait_val(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (val_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_val: val_valid=%b, required 1 within 100 cycles", val_valid);
    end
  endtask

  task automatic do_sample(input logic [3:0] logn, input int nw, input int max_gap,
                           output logic [31:0] got, output int lat, output bit ok);
    bit okw;
    got = '0;
    lat = 0;
    ok  = 1'b0;
    cfg_logn = logn;
    for (int i = 0; i < nw; i++) begin
      send_word(wbuf[i], max_gap, okw);
      if (!okw) return;
      if (i == 0) cfg_logn = 4'($urandom);
    end
    wait_val(lat, ok);
    got = val;
  endtask

  task automatic handshake;
    @(negedge clk);
    val_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    r_valid = 1'b1;
    r_word = MAXP;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (r_ready !== 1'b0 || val_valid !== 1'b0 || val !== 32'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: r_ready=%b val_valid=%b val=%0d busy=%b, required 0 0 0 0",
                 r_ready, val_valid, val, busy);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    r_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (r_ready !== 1'b1 || val_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: r_ready=%b val_valid=%b busy=%b, required 1 0 0",
               r_ready, val_valid, busy);
    end
  endtask

  task automatic test_basic;
    logic [31:0] got;
    int lat;
    bit ok;
    for (int i = 0; i < 4; i++) wbuf[i] = MAXP;
    val_ready = 1'b1;
    do_sample(4'd9, 4, 0, got, lat, ok);
    n_checks++;
    if (got !== 32'sd2 || lat != 14) begin
      n_fail++;
      $display("FAIL basic: val=%0d latency=%0d, required 2 and 14", $signed(got), lat);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (val_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: val_valid=%b busy=%b, required 0 0", val_valid, busy);
    end
  endtask

  task automatic test_sign_and_f;
    logic [31:0] got;
    int lat;
    bit ok;
    wbuf[0] = ONES; wbuf[1] = MAXP; wbuf[2] = ONES; wbuf[3] = MAXP;
    do_sample(4'd9, 4, 0, got, lat, ok);
    n_checks++;
    if (got !== -32'sd2) begin
      n_fail++;
      $display("FAIL negative: val=%0d, required -2", $signed(got));
    end
    @(posedge clk);
    #1;
    wbuf[0] = 64'd0; wbuf[1] = MAXP; wbuf[2] = 64'd0; wbuf[3] = MAXP;
    do_sample(4'd9, 4, 1, got, lat, ok);
    n_checks++;
    if (got !== 32'sd0) begin
      n_fail++;
      $display("FAIL f_suppress: val=%0d, required 0", $signed(got));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_g_one;
    logic [31:0] got;
    int lat, exp;
    bit ok;
    logic [3:0] lg [0:3];
    lg[0] = 4'd10; lg[1] = 4'd0; lg[2] = 4'd11; lg[3] = 4'd15;
    wbuf[0] = MAXP; wbuf[1] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      exp = model(lg[i]);
      do_sample(lg[i], 2, 0, got, lat, ok);
      n_checks++;
      if (got !== 32'(exp) || lat != 14) begin
        n_fail++;
        $display("FAIL g_one logn=%0d: val=%0d latency=%0d, required %0d and 14",
                 lg[i], $signed(got), lat, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] got;
    int lat, exp;
    bit ok;
    for (int i = 0; i < 4; i++) wbuf[i] = MAXP;
    val_ready = 1'b0;
    do_sample(4'd9, 4, 0, got, lat, ok);
    n_checks++;
    if (got !== 32'sd2 || lat != 14) begin
      n_fail++;
      $display("FAIL bp_first: val=%0d latency=%0d, required 2 and 14", $signed(got), lat);
    end
    @(negedge clk);
    cfg_logn = 4'd9;
    r_valid = 1'b1;
    r_word = ONES;
    repeat (5) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (val !== 32'sd2 || val_valid !== 1'b1 || r_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall: val=%0d val_valid=%b r_ready=%b busy=%b, required 2 1 0 1",
                 $signed(val), val_valid, r_ready, busy);
      end
    end
    handshake();
    n_checks++;
    if (val_valid !== 1'b0 || busy !== 1'b0 || r_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handshake: val_valid=%b busy=%b r_ready=%b, required 0 0 1",
               val_valid, busy, r_ready);
    end
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept_after: busy=%b, required 1", busy);
    end
    wbuf[0] = ONES; wbuf[1] = MAXP; wbuf[2] = MAXP; wbuf[3] = 64'd0;
    exp = model(4'd9);
    for (int i = 1; i < 4; i++) send_word(wbuf[i], 0, ok);
    wait_val(lat, ok);
    got = val;
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL bp_held_word: val=%0d, required %0d", $signed(got), exp);
    end
    handshake();
  endtask

  task automatic test_reset_mid;
    logic [31:0] got;
    int lat, exp;
    bit ok, seen;
    for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
    cfg_logn = 4'd9;
    for (int i = 0; i < 3; i++) send_word(wbuf[i], 3, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (val_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: val_valid_seen=%b busy=%b, required 0 0", seen, busy);
    end
    for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom} >> $urandom_range(0, 63);
    exp = model(4'd9);
    do_sample(4'd9, 4, 3, got, lat, ok);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL after_reset: val=%0d, required %0d", $signed(got), exp);
    end
    handshake();
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    int lat;
    bit ok;
    for (int i = 0; i < 4; i++) wbuf[i] = MAXP;
    val_ready = 1'b1;
    do_sample(4'd9, 4, 0, got, lat, ok);
    @(posedge clk);
    #1;
    n_checks++;
    if (r_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: r_ready=%b busy=%b, required 1 0", r_ready, busy);
    end
  endtask

  task automatic test_random;
    logic [31:0] got;
    logic [3:0] lg;
    int lat, exp, nw;
    bit ok;
    for (int s = 0; s < 62; s++) begin
      lg = (s == 0) ? 4'd1 : (s == 1) ? 4'd2 : 4'($urandom_range(3, 10));
      nw = 2 * g_of(lg);
      for (int i = 0; i < nw; i++) begin
        wbuf[i] = {$urandom, $urandom};
        if (i % 2 == 1) wbuf[i] = wbuf[i] >> $urandom_range(0, 63);
        else if ($urandom_range(0, 7) == 0) wbuf[i] = {wbuf[i][63], 3'b000, wbuf[i][59:0]};
      end
      exp = model(lg);
      val_ready = ($urandom_range(0, 1) == 1);
      do_sample(lg, nw, (s % 3), got, lat, ok);
      n_checks++;
      if (got !== 32'(exp) || lat != 14) begin
        n_fail++;
        $display("FAIL random s=%0d logn=%0d: val=%0d latency=%0d, required %0d and 14",
                 s, lg, $signed(got), lat, exp);
      end
      if (val_ready == 1'b0) repeat ($urandom_range(0, 3)) @(posedge clk);
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_and_f();
    test_g_one();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
